fft_frame_sched: RTL

Frame scheduler at the head of the 32-point SDF FFT pipeline. Buffers an arbitrary-rate complex sample stream and launches only complete 32-sample frames into stage 1 as gap-free 32-cycle bursts, which the per-stage cycle-counting controllers require. Handles end-of-stream zero-padding on flush. Tracks the fixed pipeline latency to flag each result's natural and bit-reversed bin index.

---
 rtl/fft_frame_sched_if.sv | 30 +++
 rtl/fft_frame_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched_if.sv
// Sample-stream, stage-1 and result-tracking signals of the FFT frame scheduler.
// master = stream source / result observer, slave = scheduler.
interface fft_frame_sched_if;
  logic               s_valid;
  logic               s_ready;
  logic signed [13:0] s_data_r;
  logic signed [13:0] s_data_i;
  logic               s_flush;
  logic               fft_valid;
  logic signed [13:0] fft_data_r;
  logic signed [13:0] fft_data_i;
  logic               out_valid;
  logic [4:0]         out_index;
  logic [4:0]         out_bitrev;
  logic               out_last;
  logic [15:0]        frames_done;
  logic               busy;

  modport master (
    output s_valid, s_data_r, s_data_i, s_flush,
    input  s_ready, fft_valid, fft_data_r, fft_data_i,
    input  out_valid, out_index, out_bitrev, out_last, frames_done, busy
  );

  modport slave (
    input  s_valid, s_data_r, s_data_i, s_flush,
    output s_ready, fft_valid, fft_data_r, fft_data_i,
    output out_valid, out_index, out_bitrev, out_last, frames_done, busy
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Input FIFO plus frame launcher for the 32-point SDF FFT: emits only whole,
// gap-free 32-beat frames, zero-pads a flushed tail, and tags results by index.
module fft_frame_sched #(
  parameter int DEPTH    = 64,
  parameter int N        = 32,
  parameter int PIPE_LAT = 36
) (
  input logic              clk,
  input logic              rst_n,
  fft_frame_sched_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = $clog2(N);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(N);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next;
  logic [BEAT_W-1:0]   pad_start_reg, pad_start_next;
  logic                pad_lock_reg, pad_lock_next;
  logic                flush_pend_reg, flush_pend_next;

  logic [27:0]         fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W:0]      avail;
  logic                wr_en, rd_en, issue, s_ready_int;

  logic                fft_valid_reg;
  logic [27:0]         fft_data_reg;
  logic [PIPE_LAT-1:0] lat_reg;
  logic [BEAT_W-1:0]   out_index_reg;
  logic [BEAT_W-1:0]   bitrev;
  logic [15:0]         frames_done_reg;
  logic                out_valid, out_last;

  assign s_ready_int = (count_reg < FULL_CNT) && !pad_lock_reg && !flush_pend_reg;
  assign wr_en       = bus.s_valid && s_ready_int;
  // Occupancy after this cycle's write; the FIFO is read one cycle ahead of
  // the beat shown on the output register, so no read term appears here.
  assign avail       = {1'b0, count_reg} + {{CNT_W{1'b0}}, wr_en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      pad_start_reg  <= '0;
      pad_lock_reg   <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      pad_start_reg  <= pad_start_next;
      pad_lock_reg   <= pad_lock_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    pad_start_next  = pad_start_reg;
    pad_lock_next   = pad_lock_reg;
    flush_pend_next = flush_pend_reg;
    case (state_reg)
      IDLE: begin
        if (count_reg >= FRAME_CNT) begin
          state_next    = STREAM;
          beat_next     = '0;
          pad_lock_next = 1'b0;
        end else if (flush_pend_reg && (count_reg != '0)) begin
          state_next     = STREAM;
          beat_next      = '0;
          pad_start_next = count_reg[BEAT_W-1:0];
          pad_lock_next  = 1'b1;
        end else if (flush_pend_reg) begin
          flush_pend_next = 1'b0;
        end
      end
      STREAM: begin
        if (beat_reg != LAST_BEAT) begin
          beat_next = beat_reg + 1'b1;
        end else begin
          beat_next = '0;
          if (pad_lock_reg) begin
            pad_lock_next   = 1'b0;
            flush_pend_next = 1'b0;
            state_next      = IDLE;
          end else if (avail >= {1'b0, FRAME_CNT}) begin
            state_next = STREAM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.s_flush) begin
      flush_pend_next = 1'b1;
    end
  end

  // The beat being decided now is presented from the output register next cycle.
  always_comb begin
    issue = (state_next == STREAM);
    rd_en = issue && (!pad_lock_next || (beat_next < pad_start_next));
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= {bus.s_data_r, bus.s_data_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      fft_valid_reg   <= 1'b0;
      fft_data_reg    <= '0;
      lat_reg         <= '0;
      out_index_reg   <= '0;
      frames_done_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !rd_en) begin
        count_reg <= count_reg + 1'b1;
      end else if (!wr_en && rd_en) begin
        count_reg <= count_reg - 1'b1;
      end
      fft_valid_reg <= issue;
      fft_data_reg  <= rd_en ? fifo_mem[rd_ptr_reg] : '0;
      lat_reg       <= {lat_reg[PIPE_LAT-2:0], fft_valid_reg};
      if (out_valid) out_index_reg <= out_index_reg + 1'b1;
      if (out_last) frames_done_reg <= frames_done_reg + 1'b1;
    end
  end

  assign out_valid = lat_reg[PIPE_LAT-1];
  assign out_last  = out_valid && (out_index_reg == LAST_BEAT);

  for (genvar gi = 0; gi < BEAT_W; gi++) begin : g_bitrev
    assign bitrev[gi] = out_index_reg[BEAT_W-1-gi];
  end

  assign bus.s_ready     = s_ready_int;
  assign bus.fft_valid   = fft_valid_reg;
  assign bus.fft_data_r  = fft_data_reg[27:14];
  assign bus.fft_data_i  = fft_data_reg[13:0];
  assign bus.out_valid   = out_valid;
  assign bus.out_index   = out_index_reg;
  assign bus.out_bitrev  = bitrev;
  assign bus.out_last    = out_last;
  assign bus.frames_done = frames_done_reg;
  assign bus.busy        = (state_reg != IDLE) || (|lat_reg);

endmodule
